// File: rtl/phy_rx_link_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : phy_rx_link_ctrl_if
//  Purpose  : Lane status in / link status out bundle for the RX link control
//  Revision : 1.0  initial release
// ============================================================================
interface phy_rx_link_ctrl_if;
  logic       en;
  logic       active0;
  logic       active1;
  logic       valid_in0;
  logic       valid_in1;
  logic       unstripe_en;
  logic       link_up;
  logic [2:0] state;
  logic       lead_lane;
  logic [1:0] skew_cnt;
  logic       err_timeout;
  logic       err_skew;
  logic [3:0] retrain_cnt;

  // master: the PHY-side source of lane status; slave: the link controller
  modport master (
    output en, active0, active1, valid_in0, valid_in1,
    input  unstripe_en, link_up, state, lead_lane, skew_cnt,
           err_timeout, err_skew, retrain_cnt
  );

  modport slave (
    input  en, active0, active1, valid_in0, valid_in1,
    output unstripe_en, link_up, state, lead_lane, skew_cnt,
           err_timeout, err_skew, retrain_cnt
  );
endinterface
`default_nettype wire

// File: rtl/phy_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : phy_rx_link_ctrl
//  Purpose  : Two-lane RX link training, deskew measurement and retrain FSM
//  Revision : 1.0  initial release
// ============================================================================
module phy_rx_link_ctrl #(
  parameter int SYNC_TIMEOUT   = 64,
  parameter int MAX_SKEW       = 3,
  parameter int MISMATCH_LIMIT = 4,
  parameter int RETRY_WAIT     = 4
) (
  input  wire logic          clk_f,
  input  wire logic          reset,
  phy_rx_link_ctrl_if.slave  bus
);

  localparam int c_tmr_max = (SYNC_TIMEOUT > RETRY_WAIT) ? SYNC_TIMEOUT : RETRY_WAIT;
  localparam int c_tmr_w   = $clog2(c_tmr_max) + 1;
  localparam int c_skw_w   = $clog2(MAX_SKEW + 2);
  localparam int c_mm_w    = $clog2(MISMATCH_LIMIT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_DESKEW    = 3'd2,
    ST_LINK_UP   = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_tmr_w-1:0]   timer_q, timer_d;
  logic [c_skw_w-1:0]   skew_q, skew_d;
  logic [c_mm_w-1:0]    mm_q, mm_d;
  logic [1:0]           skew_cnt_q, skew_cnt_d;
  logic                 lead_q, lead_d;
  logic                 err_to_q, err_to_d;
  logic                 err_sk_q, err_sk_d;
  logic [3:0]           retrain_q, retrain_d;
  logic                 link_up_q, link_up_d;
  logic                 unstripe_q, unstripe_d;

  logic                 lag_active;
  logic                 lead_active;
  logic [3:0]           retrain_inc;

  assign lag_active  = lead_q ? bus.active0 : bus.active1;
  assign lead_active = lead_q ? bus.active1 : bus.active0;
  assign retrain_inc = (retrain_q == 4'hF) ? retrain_q : retrain_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    skew_d     = skew_q;
    mm_d       = mm_q;
    skew_cnt_d = skew_cnt_q;
    lead_d     = lead_q;
    err_to_d   = err_to_q;
    err_sk_d   = err_sk_q;
    retrain_d  = retrain_q;

    // Dropping enable parks the link from any state; flags and counters persist.
    if (!bus.en) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_SYNC;
          timer_d = '0;
        end

        ST_WAIT_SYNC: begin
          timer_d = timer_q + c_tmr_w'(1);
          if (bus.active0 && bus.active1) begin
            state_d    = ST_LINK_UP;
            skew_cnt_d = 2'd0;
            lead_d     = 1'b0;
            mm_d       = '0;
          end else if (bus.active0 ^ bus.active1) begin
            state_d = ST_DESKEW;
            lead_d  = bus.active1;
            skew_d  = c_skw_w'(1);
          end else if (timer_q == c_tmr_w'(SYNC_TIMEOUT - 1)) begin
            state_d  = ST_ERROR;
            err_to_d = 1'b1;
            timer_d  = '0;
          end
        end

        ST_DESKEW: begin
          if (lag_active) begin
            state_d    = ST_LINK_UP;
            skew_cnt_d = 2'(skew_q);
            mm_d       = '0;
          end else if (!lead_active) begin
            state_d = ST_WAIT_SYNC;
            timer_d = '0;
          end else if (skew_q == c_skw_w'(MAX_SKEW)) begin
            state_d  = ST_ERROR;
            err_sk_d = 1'b1;
            timer_d  = '0;
          end else begin
            skew_d = skew_q + c_skw_w'(1);
          end
        end

        ST_LINK_UP: begin
          // Sync loss is checked before the lane-valid mismatch tracker.
          if (!bus.active0 || !bus.active1) begin
            state_d   = ST_WAIT_SYNC;
            timer_d   = '0;
            retrain_d = retrain_inc;
          end else if (bus.valid_in0 != bus.valid_in1) begin
            if (mm_q == c_mm_w'(MISMATCH_LIMIT - 1)) begin
              state_d  = ST_ERROR;
              err_sk_d = 1'b1;
              timer_d  = '0;
              mm_d     = '0;
            end else begin
              mm_d = mm_q + c_mm_w'(1);
            end
          end else begin
            mm_d = '0;
          end
        end

        ST_ERROR: begin
          if (timer_q == c_tmr_w'(RETRY_WAIT - 1)) begin
            state_d   = ST_WAIT_SYNC;
            timer_d   = '0;
            retrain_d = retrain_inc;
          end else begin
            timer_d = timer_q + c_tmr_w'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end

    link_up_d  = (state_d == ST_LINK_UP);
    unstripe_d = (state_d == ST_LINK_UP);
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      skew_q     <= '0;
      mm_q       <= '0;
      skew_cnt_q <= 2'd0;
      lead_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_sk_q   <= 1'b0;
      retrain_q  <= 4'd0;
      link_up_q  <= 1'b0;
      unstripe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      skew_q     <= skew_d;
      mm_q       <= mm_d;
      skew_cnt_q <= skew_cnt_d;
      lead_q     <= lead_d;
      err_to_q   <= err_to_d;
      err_sk_q   <= err_sk_d;
      retrain_q  <= retrain_d;
      link_up_q  <= link_up_d;
      unstripe_q <= unstripe_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.link_up     = link_up_q;
  assign bus.unstripe_en = unstripe_q;
  assign bus.lead_lane   = lead_q;
  assign bus.skew_cnt    = skew_cnt_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_skew    = err_sk_q;
  assign bus.retrain_cnt = retrain_q;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phy_rx_link_ctrl
//  Purpose  : Scenario bench for phy_rx_link_ctrl with an expected-value queue
//  Revision : 1.0  initial release
// ============================================================================
module tb_phy_rx_link_ctrl;

  logic clk_f = 1'b0;
  logic reset;
  always #5 clk_f = ~clk_f;

  phy_rx_link_ctrl_if bus ();

  phy_rx_link_ctrl #(
    .SYNC_TIMEOUT   (64),
    .MAX_SKEW       (3),
    .MISMATCH_LIMIT (4),
    .RETRY_WAIT     (4)
  ) dut (
    .clk_f (clk_f),
    .reset (reset),
    .bus   (bus)
  );

  // {rst_n, en, active0, active1, valid_in0, valid_in1}
  typedef struct packed {
    logic rn, e, a0, a1, v0, v1;
  } stim_t;

  stim_t       stim_q[$];
  logic [13:0] sb[$];
  int          total = 0;
  int          bad   = 0;

  function automatic stim_t s_(input logic rn, e, a0, a1, v0, v1);
    stim_t s;
    s = '{rn: rn, e: e, a0: a0, a1: a1, v0: v0, v1: v1};
    return s;
  endfunction

  // {state, link_up, unstripe_en, lead_lane, skew_cnt, err_timeout, err_skew, retrain_cnt}
  function automatic logic [13:0] ex(input logic [2:0] st, input logic ld,
                                     input logic [1:0] sk, input logic eto,
                                     input logic esk, input logic [3:0] rt);
    logic up;
    up = (st == 3'd3);
    return {st, up, up, ld, sk, eto, esk, rt};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.state, bus.link_up, bus.unstripe_en, bus.lead_lane, bus.skew_cnt,
            bus.err_timeout, bus.err_skew, bus.retrain_cnt};
  endfunction

  task automatic sched(input stim_t s, input logic [13:0] x);
    stim_q.push_back(s);
    sb.push_back(x);
  endtask

  task automatic cyc(input stim_t s);
    @(negedge clk_f);
    reset         = s.rn;
    bus.en        = s.e;
    bus.active0   = s.a0;
    bus.active1   = s.a1;
    bus.valid_in0 = s.v0;
    bus.valid_in1 = s.v1;
    @(posedge clk_f);
    #1;
  endtask

  task automatic do_reset();
    cyc(s_(0, 0, 0, 0, 0, 0));
    cyc(s_(0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    logic [13:0] got, e;
    int n = 0;
    sched(s_(0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0));
    sched(s_(0, 1, 1, 1, 1, 0), ex(0, 0, 0, 0, 0, 0));
    sched(s_(1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_sync_both();
    logic [13:0] got, e;
    int n = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 1, 1), ex(3, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL sync_both step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_deskew();
    logic [13:0] got, e;
    int n = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 0, 1, 0, 0), ex(2, 1, 0, 0, 0, 0));
    sched(s_(1, 1, 0, 1, 0, 0), ex(2, 1, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 1, 2, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 1, 1), ex(3, 1, 2, 0, 0, 0));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL deskew step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_skew_err();
    logic [13:0] got, e;
    int n = 0;
    do_reset();
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 3; i++) sched(s_(1, 1, 1, 0, 0, 0), ex(2, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 0, 0, 0), ex(4, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 3; i++) sched(s_(1, 1, 0, 0, 0, 0), ex(4, 0, 0, 0, 1, 0));
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 1, 1));
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 1, 1));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL skew_err step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_timeout();
    logic [13:0] got, e;
    int n = 0;
    do_reset();
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 63; i++) sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 0, 0, 0, 0), ex(4, 0, 0, 1, 0, 0));
    sched(s_(1, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0, 0));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL timeout step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
    // An active on the very last waiting cycle beats the timeout.
    do_reset();
    n = 0;
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 63; i++) sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 0, 0, 0), ex(2, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL timeout_edge step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_linkup_drop();
    logic [13:0] got, e;
    int n = 0;
    do_reset();
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 0, 1, 0, 0), ex(1, 0, 0, 0, 0, 1));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, 1));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL linkup_drop step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_mismatch();
    logic [13:0] got, e;
    int n = 0;
    do_reset();
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) sched(s_(1, 1, 1, 1, 1, 0), ex(3, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 1, 1), ex(3, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) sched(s_(1, 1, 1, 1, 0, 1), ex(3, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 1), ex(4, 0, 0, 0, 1, 0));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL mismatch step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
    // Sync loss coinciding with the final mismatch cycle retrains instead.
    do_reset();
    n = 0;
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) sched(s_(1, 1, 1, 1, 1, 0), ex(3, 0, 0, 0, 0, 0));
    sched(s_(1, 1, 1, 0, 1, 0), ex(1, 0, 0, 0, 0, 1));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL mismatch_prio step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_retrain_sat();
    logic [13:0] got, e;
    logic [3:0]  rt;
    int n = 0;
    do_reset();
    rt = 4'd0;
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      sched(s_(1, 1, 1, 1, 0, 0), ex(3, 0, 0, 0, 0, rt));
      rt = (k > 15) ? 4'd15 : 4'(k);
      sched(s_(1, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, rt));
    end
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL retrain_sat step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] got, e;
    int n = 0;
    // Continues from the saturated retrain state: WAIT_SYNC, retrain_cnt=15.
    sched(s_(1, 1, 0, 1, 0, 0), ex(2, 1, 0, 0, 0, 15));
    sched(s_(1, 1, 0, 1, 0, 0), ex(2, 1, 0, 0, 0, 15));
    sched(s_(1, 1, 1, 1, 0, 0), ex(3, 1, 2, 0, 0, 15));
    sched(s_(1, 1, 0, 0, 0, 0), ex(1, 1, 2, 0, 0, 15));
    sched(s_(1, 1, 0, 1, 0, 0), ex(2, 1, 2, 0, 0, 15));
    sched(s_(0, 1, 0, 1, 0, 0), ex(0, 0, 0, 0, 0, 0));
    sched(s_(1, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0));
    while (stim_q.size() > 0) begin
      cyc(stim_q.pop_front());
      got = obs(); e = sb.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_mid step%0d got=%h exp=%h", n, got, e); end
      n++;
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.en        = 1'b0;
    bus.active0   = 1'b0;
    bus.active1   = 1'b0;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    test_reset();
    test_sync_both();
    test_deskew();
    test_skew_err();
    test_timeout();
    test_linkup_drop();
    test_mismatch();
    test_retrain_sat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
